// File: rtl/pipeline_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package pipeline_pkg;

  localparam int REG_W = 6;
  localparam logic [31:0] SYSCALL_EXIT = 32'd10;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX observation signals and PC/IF_ID/ID_EX control lines of the hazard controller.
interface hazard_ctrl_if #(
  parameter int REG_W  = pipeline_pkg::REG_W,
  parameter int DATA_W = 32
);

  logic [REG_W-1:0]  id_r1_num;
  logic [REG_W-1:0]  id_r2_num;
  logic              id_r1_used;
  logic              id_r2_used;
  logic              ex_ld;
  logic              ex_regwrite;
  logic [REG_W-1:0]  ex_write;
  logic              ex_jump;
  logic              ex_br_taken;
  logic              ex_syscall;
  logic [DATA_W-1:0] ex_v0;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_zero;
  logic              idex_en;
  logic              idex_zero;

  // The pipeline datapath is the master; the hazard controller is the slave.
  modport master (
    output id_r1_num, id_r2_num, id_r1_used, id_r2_used,
    output ex_ld, ex_regwrite, ex_write, ex_jump, ex_br_taken,
    output ex_syscall, ex_v0,
    input  pc_en, ifid_en, ifid_zero, idex_en, idex_zero
  );

  modport slave (
    input  id_r1_num, id_r2_num, id_r1_used, id_r2_used,
    input  ex_ld, ex_regwrite, ex_write, ex_jump, ex_br_taken,
    input  ex_syscall, ex_v0,
    output pc_en, ifid_en, ifid_zero, idex_en, idex_zero
  );

endinterface

// File: rtl/perf_counters.sv
// Four wrapping event counters with increment strobes, a freeze input and async clear.
module perf_counters #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               inc_cyc,
  input  logic               inc_jmp,
  input  logic               inc_br,
  input  logic               inc_lu,
  output logic [COUNT_W-1:0] cyc_cnt,
  output logic [COUNT_W-1:0] jmp_cnt,
  output logic [COUNT_W-1:0] br_cnt,
  output logic [COUNT_W-1:0] lu_cnt
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      jmp_cnt <= '0;
      br_cnt  <= '0;
      lu_cnt  <= '0;
    end else if (!freeze) begin
      if (inc_cyc) cyc_cnt <= cyc_cnt + ONE;
      if (inc_jmp) jmp_cnt <= jmp_cnt + ONE;
      if (inc_br)  br_cnt  <= br_cnt + ONE;
      if (inc_lu)  lu_cnt  <= lu_cnt + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump squash, syscall-exit halt
// with resume, and performance counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W   = pipeline_pkg::REG_W,
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_ctrl_if.slave       bus,
  input  logic               go,
  output logic               halted,
  output logic [COUNT_W-1:0] cyc_cnt,
  output logic [COUNT_W-1:0] jmp_cnt,
  output logic [COUNT_W-1:0] br_cnt,
  output logic [COUNT_W-1:0] lu_cnt
);

  ctrl_state_t state;
  logic        redirect;
  logic        exit_req;
  logic        lu;
  logic        lu_sel;
  logic        r1_hit;
  logic        r2_hit;

  assign redirect = bus.ex_jump | bus.ex_br_taken;
  assign exit_req = bus.ex_syscall & (bus.ex_v0 == DATA_W'(SYSCALL_EXIT));
  assign r1_hit   = bus.id_r1_used & (bus.id_r1_num == bus.ex_write);
  assign r2_hit   = bus.id_r2_used & (bus.id_r2_num == bus.ex_write);
  assign lu       = bus.ex_ld & bus.ex_regwrite &
                    (bus.ex_write != REG_W'(REG_ZERO)) & (r1_hit | r2_hit);
  // A redirect squashes the ID instruction, so its hazard is irrelevant.
  assign lu_sel   = (state == RUN) & ~redirect & ~exit_req & lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (exit_req && !redirect) state <= HALT;
        HALT:    if (go) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_en     = 1'b1;
    bus.ifid_en   = 1'b1;
    bus.ifid_zero = 1'b0;
    bus.idex_en   = 1'b1;
    bus.idex_zero = 1'b0;
    halted        = 1'b0;
    if (rst) begin
      bus.pc_en     = 1'b0;
      bus.ifid_en   = 1'b0;
      bus.idex_en   = 1'b0;
      bus.ifid_zero = 1'b1;
      bus.idex_zero = 1'b1;
    end else if (state == HALT) begin
      bus.pc_en   = 1'b0;
      bus.ifid_en = 1'b0;
      bus.idex_en = 1'b0;
      halted      = 1'b1;
    end else if (redirect) begin
      bus.ifid_zero = 1'b1;
      bus.idex_zero = 1'b1;
    end else if (exit_req || lu) begin
      // Hold PC and IF_ID, push a bubble into EX.
      bus.pc_en     = 1'b0;
      bus.ifid_en   = 1'b0;
      bus.idex_zero = 1'b1;
    end
  end

  perf_counters #(
    .COUNT_W (COUNT_W)
  ) u_counters (
    .clk     (clk),
    .rst     (rst),
    .freeze  (state == HALT),
    .inc_cyc (1'b1),
    .inc_jmp (bus.ex_jump),
    .inc_br  (bus.ex_br_taken & ~bus.ex_jump),
    .inc_lu  (lu_sel),
    .cyc_cnt (cyc_cnt),
    .jmp_cnt (jmp_cnt),
    .br_cnt  (br_cnt),
    .lu_cnt  (lu_cnt)
  );

endmodule
